// File: rtl/control_trans.sv
// Transition-counter controller: clears, increments (round-robin arbitrated
// read-modify-write) and dumps a bank of 32-bit counters in external memory.
module control_trans #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_CNTR = 16,
  parameter int unsigned NREQ     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inicio_borrado,
  input  logic                   inicio_lectura,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_dir,
  input  logic [31:0]            dato_rd,
  output logic [ADDR_W-1:0]      dir,
  output logic                   LE,
  output logic [31:0]            dato_wr,
  output logic [NREQ-1:0]        gnt,
  output logic                   ocupado,
  output logic [31:0]            contador,
  output logic [ADDR_W-1:0]      cont_dir,
  output logic                   cont_valido,
  output logic [31:0]            suma,
  output logic                   suma_desb,
  output logic                   listo
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RD, S_WR, S_DUMP} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CNTR - 1);

  state_t            state_q;
  logic [NREQ-1:0]   rr_mask_q;
  logic [ADDR_W-1:0] dir_q;
  logic              le_q;
  logic [31:0]       dato_wr_q;
  logic [NREQ-1:0]   gnt_q;
  logic [31:0]       contador_q;
  logic [ADDR_W-1:0] cont_dir_q;
  logic              cont_valido_q;
  logic [31:0]       suma_q;
  logic              suma_desb_q;
  logic              listo_q;

  logic [NREQ-1:0]   req_hi, req_sel, gnt_d, rr_mask_d;
  logic [ADDR_W-1:0] win_dir;
  logic              addr_ok;
  logic [31:0]       inc_val;
  logic [32:0]       sum_ext;

  // The pointer is kept as a mask of requesters at or after ptr; an empty
  // mask (winner was the last requester) behaves as ptr=0.
  always_comb begin
    req_hi    = req & rr_mask_q;
    req_sel   = (req_hi != '0) ? req_hi : req;
    gnt_d     = req_sel & (~req_sel + NREQ'(1));
    rr_mask_d = ~((gnt_d << 1) - NREQ'(1));
    win_dir   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_d[i]) win_dir = req_dir[i*ADDR_W +: ADDR_W];
    end
  end

  assign addr_ok = ({1'b0, dir_q} < (ADDR_W+1)'(NUM_CNTR));
  assign inc_val = (dato_rd == '1) ? dato_rd : dato_rd + 32'd1;
  assign sum_ext = {1'b0, suma_q} + {1'b0, dato_rd};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_mask_q     <= '1;
      dir_q         <= '0;
      le_q          <= 1'b1;
      dato_wr_q     <= '0;
      gnt_q         <= '0;
      contador_q    <= '0;
      cont_dir_q    <= '0;
      cont_valido_q <= 1'b0;
      suma_q        <= '0;
      suma_desb_q   <= 1'b0;
      listo_q       <= 1'b0;
    end else begin
      gnt_q         <= '0;
      cont_valido_q <= 1'b0;
      listo_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          le_q <= 1'b1;
          if (inicio_borrado) begin
            state_q   <= S_CLEAR;
            le_q      <= 1'b0;
            dir_q     <= '0;
            dato_wr_q <= '0;
          end else if (inicio_lectura) begin
            state_q     <= S_DUMP;
            dir_q       <= '0;
            suma_q      <= '0;
            suma_desb_q <= 1'b0;
          end else if (req != '0) begin
            state_q   <= S_RD;
            gnt_q     <= gnt_d;
            rr_mask_q <= rr_mask_d;
            dir_q     <= win_dir;
          end
        end
        S_CLEAR: begin
          if (dir_q == LAST) begin
            state_q <= S_IDLE;
            le_q    <= 1'b1;
          end else begin
            dir_q <= dir_q + ADDR_W'(1);
          end
        end
        S_RD: begin
          state_q <= S_WR;
          // Out-of-range addresses keep the bus in read mode during WR.
          if (addr_ok) begin
            le_q      <= 1'b0;
            dato_wr_q <= inc_val;
          end
        end
        S_WR: begin
          state_q <= S_IDLE;
          le_q    <= 1'b1;
        end
        S_DUMP: begin
          contador_q    <= dato_rd;
          cont_dir_q    <= dir_q;
          cont_valido_q <= 1'b1;
          suma_q        <= sum_ext[31:0];
          if (sum_ext[32]) suma_desb_q <= 1'b1;
          if (dir_q == LAST) begin
            state_q <= S_IDLE;
            listo_q <= 1'b1;
          end else begin
            dir_q <= dir_q + ADDR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dir         = dir_q;
  assign LE          = le_q;
  assign dato_wr     = dato_wr_q;
  assign gnt         = gnt_q;
  assign ocupado     = (state_q != S_IDLE);
  assign contador    = contador_q;
  assign cont_dir    = cont_dir_q;
  assign cont_valido = cont_valido_q;
  assign suma        = suma_q;
  assign suma_desb   = suma_desb_q;
  assign listo       = listo_q;

endmodule

// File: tb/tb_control_trans.sv
// Bench for control_trans: external counter memory plus a reference model of
// counter values and round-robin pointer derived from the block's rules.
module tb_control_trans;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_CNTR = 16;
  localparam int unsigned NREQ     = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   inicio_borrado;
  logic                   inicio_lectura;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_dir;
  logic [31:0]            dato_rd;
  logic [ADDR_W-1:0]      dir;
  logic                   LE;
  logic [31:0]            dato_wr;
  logic [NREQ-1:0]        gnt;
  logic                   ocupado;
  logic [31:0]            contador;
  logic [ADDR_W-1:0]      cont_dir;
  logic                   cont_valido;
  logic [31:0]            suma;
  logic                   suma_desb;
  logic                   listo;

  logic [31:0] mem     [NUM_CNTR];
  logic [31:0] ref_cnt [NUM_CNTR];
  int unsigned rr_ptr;
  int checks = 0;
  int errors = 0;

  control_trans #(.ADDR_W(ADDR_W), .NUM_CNTR(NUM_CNTR), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .inicio_borrado(inicio_borrado),
    .inicio_lectura(inicio_lectura), .req(req), .req_dir(req_dir),
    .dato_rd(dato_rd), .dir(dir), .LE(LE), .dato_wr(dato_wr), .gnt(gnt),
    .ocupado(ocupado), .contador(contador), .cont_dir(cont_dir),
    .cont_valido(cont_valido), .suma(suma), .suma_desb(suma_desb), .listo(listo)
  );

  always #5 clk = ~clk;

  assign dato_rd = mem[dir];
  always @(posedge clk) if (LE == 1'b0) mem[dir] <= dato_wr;

  function automatic int unsigned model_winner(input logic [NREQ-1:0] r);
    for (int unsigned off = 0; off < NREQ; off++)
      if (r[(rr_ptr + off) % NREQ]) return (rr_ptr + off) % NREQ;
    return 0;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rr_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inicio_borrado = 1'b1; inicio_lectura = 1'b1;
    req = '1; req_dir = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ocupado !== 1'b0 || LE !== 1'b1 || dir !== '0 || dato_wr !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_bus: ocupado=%b LE=%b dir=%0d dato_wr=%h gnt=%b, want 0 1 0 0 0",
               ocupado, LE, dir, dato_wr, gnt);
    end
    checks++;
    if (contador !== '0 || cont_dir !== '0 || cont_valido !== 1'b0 || suma !== '0 ||
        suma_desb !== 1'b0 || listo !== 1'b0) begin
      errors++;
      $display("FAIL reset_dump: contador=%h cont_dir=%0d valido=%b suma=%h desb=%b listo=%b, want all 0",
               contador, cont_dir, cont_valido, suma, suma_desb, listo);
    end
    inicio_borrado = 1'b0; inicio_lectura = 1'b0; req = '0;
    reset = 1'b0;
    rr_ptr = 0;
    @(negedge clk);
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ocupado=%b want 0", ocupado);
    end
  endtask

  // with_others: dump and increment requests arrive together with the clear
  task automatic test_clear(input bit with_others);
    inicio_borrado = 1'b1;
    if (with_others) begin
      inicio_lectura = 1'b1; req = '1; req_dir = '0;
    end
    @(negedge clk);
    inicio_borrado = 1'b0; inicio_lectura = 1'b0; req = '0;
    for (int unsigned k = 0; k < NUM_CNTR; k++) begin
      checks++;
      if (LE !== 1'b0 || dir !== ADDR_W'(k) || dato_wr !== '0 || ocupado !== 1'b1 ||
          gnt !== '0 || cont_valido !== 1'b0) begin
        errors++;
        $display("FAIL clear_cycle%0d: LE=%b dir=%0d dato_wr=%h ocupado=%b gnt=%b valido=%b, want 0 %0d 0 1 0 0",
                 k, LE, dir, dato_wr, ocupado, gnt, cont_valido, k);
      end
      inicio_lectura = (k == 3);
      @(negedge clk);
    end
    inicio_lectura = 1'b0;
    checks++;
    if (ocupado !== 1'b0 || LE !== 1'b1) begin
      errors++;
      $display("FAIL clear_end: ocupado=%b LE=%b, want 0 1", ocupado, LE);
    end
    for (int unsigned k = 0; k < NUM_CNTR; k++) begin
      ref_cnt[k] = '0;
      checks++;
      if (mem[k] !== 32'd0) begin
        errors++;
        $display("FAIL clear_mem%0d: mem=%h want 0", k, mem[k]);
      end
    end
  endtask

  task automatic test_single_inc();
    mem[3] = 32'd7; ref_cnt[3] = 32'd7;
    req = 4'b0001;
    req_dir = {ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'(3)};
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || LE !== 1'b1 || dir !== ADDR_W'(3) || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL single_rd: gnt=%b LE=%b dir=%0d ocupado=%b, want 0001 1 3 1", gnt, LE, dir, ocupado);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || LE !== 1'b0 || dir !== ADDR_W'(3) || dato_wr !== 32'd8) begin
      errors++;
      $display("FAIL single_wr: gnt=%b LE=%b dir=%0d dato_wr=%0d, want 0000 0 3 8", gnt, LE, dir, dato_wr);
    end
    @(negedge clk);
    checks++;
    if (ocupado !== 1'b0 || mem[3] !== 32'd8) begin
      errors++;
      $display("FAIL single_done: ocupado=%b mem3=%0d, want 0 8", ocupado, mem[3]);
    end
    ref_cnt[3] = 32'd8;
    rr_ptr = 1;
  endtask

  // rnd=0: all requesters hold req with address 0; rnd=1: random arrivals
  task automatic run_incs(input int n, input bit rnd);
    logic [NREQ-1:0]        pend;
    logic [NREQ*ADDR_W-1:0] dirs;
    int unsigned            w;
    logic [ADDR_W-1:0]      a;
    pend = '0; dirs = '0;
    for (int t = 0; t < n; t++) begin
      if (!rnd) pend = '1;
      else begin
        for (int unsigned i = 0; i < NREQ; i++)
          if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i] = 1'b1;
            dirs[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, NUM_CNTR - 1));
          end
        if (pend == '0) begin
          pend[0] = 1'b1;
          dirs[ADDR_W-1:0] = ADDR_W'($urandom_range(0, NUM_CNTR - 1));
        end
      end
      req = pend; req_dir = dirs;
      w = model_winner(pend);
      a = dirs[w*ADDR_W +: ADDR_W];
      @(negedge clk);
      checks++;
      if (gnt !== NREQ'(1 << w) || dir !== a || LE !== 1'b1) begin
        errors++;
        $display("FAIL inc%0d_grant: gnt=%b dir=%0d LE=%b, want %b %0d 1", t, gnt, dir, LE, NREQ'(1 << w), a);
      end
      pend[w] = 1'b0;
      if (rnd) req = pend;
      rr_ptr = (w + 1) % NREQ;
      @(negedge clk);
      checks++;
      if (gnt !== '0 || LE !== 1'b0 || dir !== a || dato_wr !== sat_inc(ref_cnt[a])) begin
        errors++;
        $display("FAIL inc%0d_write: gnt=%b LE=%b dir=%0d dato_wr=%h, want 0 0 %0d %h",
                 t, gnt, LE, dir, dato_wr, a, sat_inc(ref_cnt[a]));
      end
      ref_cnt[a] = sat_inc(ref_cnt[a]);
      @(negedge clk);
      checks++;
      if (ocupado !== 1'b0 || mem[a] !== ref_cnt[a]) begin
        errors++;
        $display("FAIL inc%0d_done: ocupado=%b mem[%0d]=%h, want 0 %h", t, ocupado, a, mem[a], ref_cnt[a]);
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    run_incs(5, 1'b0);
    checks++;
    if (mem[0] !== 32'd5) begin
      errors++;
      $display("FAIL rr_count: mem0=%0d want 5", mem[0]);
    end
  endtask

  task automatic test_saturate();
    int unsigned r;
    r = $urandom_range(0, NREQ - 1);
    mem[2] = 32'hFFFF_FFFF; ref_cnt[2] = 32'hFFFF_FFFF;
    req = NREQ'(1 << r);
    req_dir = '0;
    req_dir[r*ADDR_W +: ADDR_W] = ADDR_W'(2);
    @(negedge clk);
    req = '0;
    rr_ptr = (r + 1) % NREQ;
    @(negedge clk);
    checks++;
    if (LE !== 1'b0 || dir !== ADDR_W'(2) || dato_wr !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sat_write: LE=%b dir=%0d dato_wr=%h, want 0 2 ffffffff", LE, dir, dato_wr);
    end
    @(negedge clk);
    checks++;
    if (mem[2] !== 32'hFFFF_FFFF || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL sat_mem: mem2=%h ocupado=%b, want ffffffff 0", mem[2], ocupado);
    end
  endtask

  task automatic run_dump();
    longint unsigned total;
    int unsigned     n;
    logic [31:0]     h_cont, h_suma;
    logic [ADDR_W-1:0] h_dir;
    total = 0; n = 0;
    inicio_lectura = 1'b1;
    @(negedge clk);
    inicio_lectura = 1'b0;
    for (int cyc = 0; cyc < 3 * NUM_CNTR && n < NUM_CNTR; cyc++) begin
      @(negedge clk);
      if (cont_valido === 1'b1) begin
        total += longint'(ref_cnt[n]);
        checks++;
        if (contador !== ref_cnt[n] || cont_dir !== ADDR_W'(n) || listo !== (n == NUM_CNTR - 1) ||
            suma !== total[31:0]) begin
          errors++;
          $display("FAIL dump_pulse%0d: contador=%h cont_dir=%0d listo=%b suma=%h, want %h %0d %b %h",
                   n, contador, cont_dir, listo, suma, ref_cnt[n], n, (n == NUM_CNTR - 1), total[31:0]);
        end
        n++;
      end else if (listo !== 1'b0) begin
        checks++; errors++;
        $display("FAIL dump_listo: listo=1 without cont_valido at pulse %0d", n);
      end
    end
    checks++;
    if (n != NUM_CNTR || suma_desb !== (total > 64'hFFFF_FFFF) || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL dump_end: pulses=%0d desb=%b ocupado=%b, want %0d %b 0",
               n, suma_desb, ocupado, NUM_CNTR, (total > 64'hFFFF_FFFF));
    end
    h_cont = contador; h_dir = cont_dir; h_suma = suma;
    @(negedge clk);
    checks++;
    if (cont_valido !== 1'b0 || listo !== 1'b0 || contador !== h_cont || cont_dir !== h_dir ||
        suma !== total[31:0] || h_suma !== total[31:0]) begin
      errors++;
      $display("FAIL dump_hold: valido=%b listo=%b contador=%h cont_dir=%0d suma=%h, want 0 0 %h %0d %h",
               cont_valido, listo, contador, cont_dir, suma, h_cont, h_dir, total[31:0]);
    end
  endtask

  task automatic test_dump();
    for (int unsigned k = 0; k < NUM_CNTR; k++) begin
      mem[k] = 32'(k + 1); ref_cnt[k] = 32'(k + 1);
    end
    run_dump();
    checks++;
    if (suma !== 32'd136 || suma_desb !== 1'b0) begin
      errors++;
      $display("FAIL dump_sum136: suma=%0d desb=%b, want 136 0", suma, suma_desb);
    end
    for (int unsigned k = 0; k < NUM_CNTR; k++) begin
      mem[k] = $urandom | 32'hC000_0000; ref_cnt[k] = mem[k];
    end
    run_dump();
    checks++;
    if (suma_desb !== 1'b1) begin
      errors++;
      $display("FAIL dump_overflow: desb=%b want 1", suma_desb);
    end
  endtask

  task automatic test_random();
    run_incs(40, 1'b1);
    run_dump();
  endtask

  task automatic test_reset_mid_dump();
    for (int unsigned k = 0; k < NUM_CNTR; k++) mem[k] = 32'(k + 100);
    inicio_lectura = 1'b1;
    @(negedge clk);
    inicio_lectura = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ocupado !== 1'b0 || cont_valido !== 1'b0 || suma !== '0 || listo !== 1'b0 ||
        LE !== 1'b1 || dir !== '0 || contador !== '0) begin
      errors++;
      $display("FAIL reset_mid_dump: ocupado=%b valido=%b suma=%h listo=%b LE=%b dir=%0d contador=%h, want 0 0 0 0 1 0 0",
               ocupado, cont_valido, suma, listo, LE, dir, contador);
    end
    reset = 1'b0;
    rr_ptr = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (ocupado !== 1'b0 || cont_valido !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dump_idle: ocupado=%b valido=%b, want 0 0", ocupado, cont_valido);
    end
  endtask

  initial begin
    reset = 1'b1; inicio_borrado = 1'b0; inicio_lectura = 1'b0;
    req = '0; req_dir = '0; rr_ptr = 0;
    @(negedge clk);
    test_reset();
    test_clear(1'b0);
    test_single_inc();
    do_reset();
    test_clear(1'b0);
    test_round_robin();
    test_saturate();
    test_dump();
    test_clear(1'b1);
    test_random();
    test_reset_mid_dump();
    test_clear(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
